// File: rtl/player_action_if.sv
// Frame strobe, key levels, ground flag and registered action outputs of the player controller.
interface player_action_if;
  logic       frame_tick;
  logic       up_on;
  logic       left_on;
  logic       down_on;
  logic       right_on;
  logic       z_jump_on;
  logic       x_shoot_on;
  logic       on_ground;
  logic [1:0] vert_cmd;
  logic [1:0] move_dir;
  logic       facing_right;
  logic       aim_up;
  logic       rolling;
  logic       shot_fire;

  modport master (
    output frame_tick, up_on, left_on, down_on, right_on, z_jump_on, x_shoot_on, on_ground,
    input  vert_cmd, move_dir, facing_right, aim_up, rolling, shot_fire
  );

  modport slave (
    input  frame_tick, up_on, left_on, down_on, right_on, z_jump_on, x_shoot_on, on_ground,
    output vert_cmd, move_dir, facing_right, aim_up, rolling, shot_fire
  );
endinterface

// File: rtl/player_action_ctrl.sv
// Per-frame player action controller: jump FSM, walk/facing, roll timer and shot cooldown.
module player_action_ctrl #(
  parameter int unsigned JUMP_MAX_FRAMES = 16,
  parameter int unsigned SHOT_COOLDOWN   = 8,
  parameter int unsigned ROLL_FRAMES     = 12
) (
  input logic            Clk,
  input logic            Reset_n,
  player_action_if.slave pa
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] JUMP_MAX = CNT_W'(JUMP_MAX_FRAMES);
  localparam logic [CNT_W-1:0] SHOT_CD  = CNT_W'(SHOT_COOLDOWN);
  localparam logic [CNT_W-1:0] ROLL_LEN = CNT_W'(ROLL_FRAMES);

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } jump_state_e;

  jump_state_e      state_q, state_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic [CNT_W-1:0] roll_cnt_q, roll_cnt_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic             z_prev_q, z_prev_d;
  logic             x_prev_q, x_prev_d;
  logic             down_prev_q, down_prev_d;
  logic             rolling_q, rolling_d;
  logic             facing_q, facing_d;
  logic [1:0]       move_q, move_d;
  logic             aim_q, aim_d;
  logic             shot_q, shot_d;
  logic             z_edge, x_edge, down_edge, jump_start;

  assign z_edge    = pa.z_jump_on  & ~z_prev_q;
  assign x_edge    = pa.x_shoot_on & ~x_prev_q;
  assign down_edge = pa.down_on    & ~down_prev_q;

  // State register for the jump FSM and all per-frame state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= GROUND;
      jump_cnt_q  <= '0;
      roll_cnt_q  <= '0;
      cool_q      <= '0;
      z_prev_q    <= 1'b0;
      x_prev_q    <= 1'b0;
      down_prev_q <= 1'b0;
      rolling_q   <= 1'b0;
      facing_q    <= 1'b1;
      move_q      <= DIR_STOP;
      aim_q       <= 1'b0;
      shot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      jump_cnt_q  <= jump_cnt_d;
      roll_cnt_q  <= roll_cnt_d;
      cool_q      <= cool_d;
      z_prev_q    <= z_prev_d;
      x_prev_q    <= x_prev_d;
      down_prev_q <= down_prev_d;
      rolling_q   <= rolling_d;
      facing_q    <= facing_d;
      move_q      <= move_d;
      aim_q       <= aim_d;
      shot_q      <= shot_d;
    end
  end

  // Next-state logic; everything holds except on frame_tick, and shot_fire self-clears.
  always_comb begin
    state_d     = state_q;
    jump_cnt_d  = jump_cnt_q;
    roll_cnt_d  = roll_cnt_q;
    cool_d      = cool_q;
    z_prev_d    = z_prev_q;
    x_prev_d    = x_prev_q;
    down_prev_d = down_prev_q;
    rolling_d   = rolling_q;
    facing_d    = facing_q;
    move_d      = move_q;
    aim_d       = aim_q;
    shot_d      = 1'b0;
    jump_start  = 1'b0;

    if (pa.frame_tick) begin
      z_prev_d    = pa.z_jump_on;
      x_prev_d    = pa.x_shoot_on;
      down_prev_d = pa.down_on;
      aim_d       = pa.up_on;

      unique case (state_q)
        GROUND: begin
          if (z_edge && pa.on_ground && !rolling_q) begin
            state_d    = RISE;
            jump_cnt_d = CNT_W'(1);
            jump_start = 1'b1;
          end else if (!pa.on_ground) begin
            state_d = FALL;
          end
        end
        RISE: begin
          if (!pa.z_jump_on || jump_cnt_q == JUMP_MAX) begin
            state_d    = FALL;
            jump_cnt_d = '0;
          end else begin
            jump_cnt_d = jump_cnt_q + CNT_W'(1);
          end
        end
        FALL: begin
          if (pa.on_ground) state_d = GROUND;
        end
        default: state_d = GROUND;
      endcase

      // Cooldown counts this tick before the fire test, so shots are SHOT_COOLDOWN frames apart.
      cool_d = (cool_q != '0) ? cool_q - CNT_W'(1) : '0;
      if (x_edge && cool_d == '0 && !rolling_q) begin
        shot_d = 1'b1;
        cool_d = SHOT_CD;
      end

      if (rolling_q) begin
        if (roll_cnt_q <= CNT_W'(1)) begin
          roll_cnt_d = '0;
          rolling_d  = 1'b0;
        end else begin
          roll_cnt_d = roll_cnt_q - CNT_W'(1);
        end
      end else if (state_q == GROUND && down_edge && !jump_start) begin
        rolling_d  = 1'b1;
        roll_cnt_d = ROLL_LEN;
      end

      if (rolling_d) begin
        move_d = facing_q ? DIR_RIGHT : DIR_LEFT;
      end else if (pa.left_on && !pa.right_on) begin
        move_d   = DIR_LEFT;
        facing_d = 1'b0;
      end else if (pa.right_on && !pa.left_on) begin
        move_d   = DIR_RIGHT;
        facing_d = 1'b1;
      end else begin
        move_d = DIR_STOP;
      end
    end
  end

  assign pa.vert_cmd     = state_q;
  assign pa.move_dir     = move_q;
  assign pa.facing_right = facing_q;
  assign pa.aim_up       = aim_q;
  assign pa.rolling      = rolling_q;
  assign pa.shot_fire    = shot_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Scoreboard bench for player_action_ctrl: a behavioural model queues expected outputs per frame tick.
module tb_player_action_ctrl;

  localparam int unsigned JMAX    = 16;
  localparam int unsigned SHOT_CD = 8;
  localparam int unsigned ROLLN   = 12;

  typedef struct packed {
    logic [1:0] vert;
    logic [1:0] move;
    logic       facing;
    logic       aim;
    logic       rolling;
    logic       shot;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  player_action_if pa();

  player_action_ctrl #(
    .JUMP_MAX_FRAMES(JMAX),
    .SHOT_COOLDOWN  (SHOT_CD),
    .ROLL_FRAMES    (ROLLN)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .pa     (pa)
  );

  always #5 Clk = ~Clk;

  // Stimulus levels applied at the next tick.
  logic k_up, k_left, k_down, k_right, k_z, k_x, k_gnd;

  // Reference model state.
  logic [1:0] m_vert, m_move;
  logic [7:0] m_jcnt, m_rcnt, m_cd;
  logic       m_rolling, m_facing, m_aim, m_shot, m_zp, m_xp, m_dp;

  exp_t sb_q[$];

  // Last observed outputs after a tick.
  logic [1:0] obs_vert, obs_move;
  logic       obs_facing, obs_rolling, obs_shot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vert = 2'b00; m_move = 2'b00; m_jcnt = 8'd0; m_rcnt = 8'd0; m_cd = 8'd0;
    m_rolling = 1'b0; m_facing = 1'b1; m_aim = 1'b0; m_shot = 1'b0;
    m_zp = 1'b0; m_xp = 1'b0; m_dp = 1'b0;
  endtask

  task automatic model_step();
    logic       ze, xe, de, jstart;
    logic [1:0] old_vert;
    ze = k_z & ~m_zp;
    xe = k_x & ~m_xp;
    de = k_down & ~m_dp;
    jstart = 1'b0;
    old_vert = m_vert;
    // A shot needs the previous shot to be at least SHOT_CD ticks old.
    m_shot = 1'b0;
    if (xe && !m_rolling && m_cd <= 8'd1) begin
      m_shot = 1'b1;
      m_cd = 8'(SHOT_CD);
    end else if (m_cd != 8'd0) begin
      m_cd = m_cd - 8'd1;
    end
    case (old_vert)
      2'b00: begin
        if (ze && k_gnd && !m_rolling) begin
          m_vert = 2'b01; m_jcnt = 8'd1; jstart = 1'b1;
        end else if (!k_gnd) begin
          m_vert = 2'b10;
        end
      end
      2'b01: begin
        if (!k_z || m_jcnt == 8'(JMAX)) m_vert = 2'b10;
        else m_jcnt = m_jcnt + 8'd1;
      end
      default: if (k_gnd) m_vert = 2'b00;
    endcase
    if (m_rolling) begin
      m_rcnt = m_rcnt - 8'd1;
      if (m_rcnt == 8'd0) m_rolling = 1'b0;
    end else if (old_vert == 2'b00 && de && !jstart) begin
      m_rolling = 1'b1;
      m_rcnt = 8'(ROLLN);
    end
    if (m_rolling) m_move = m_facing ? 2'b10 : 2'b01;
    else if (k_left && !k_right) begin m_move = 2'b01; m_facing = 1'b0; end
    else if (k_right && !k_left) begin m_move = 2'b10; m_facing = 1'b1; end
    else m_move = 2'b00;
    m_aim = k_up;
    m_zp = k_z;
    m_xp = k_x;
    m_dp = k_down;
  endtask

  // One frame: drive at negedge with frame_tick, compare after the edge, then one idle edge.
  task automatic tick();
    exp_t e;
    @(negedge Clk);
    pa.up_on = k_up; pa.left_on = k_left; pa.down_on = k_down; pa.right_on = k_right;
    pa.z_jump_on = k_z; pa.x_shoot_on = k_x; pa.on_ground = k_gnd;
    pa.frame_tick = 1'b1;
    model_step();
    sb_q.push_back(exp_t'{m_vert, m_move, m_facing, m_aim, m_rolling, m_shot});
    @(posedge Clk);
    #1;
    pa.frame_tick = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("vert_cmd", 32'(pa.vert_cmd), 32'(e.vert));
      check("move_dir", 32'(pa.move_dir), 32'(e.move));
      check("facing_right", 32'(pa.facing_right), 32'(e.facing));
      check("aim_up", 32'(pa.aim_up), 32'(e.aim));
      check("rolling", 32'(pa.rolling), 32'(e.rolling));
      check("shot_fire", 32'(pa.shot_fire), 32'(e.shot));
    end
    obs_vert = pa.vert_cmd; obs_move = pa.move_dir; obs_facing = pa.facing_right;
    obs_rolling = pa.rolling; obs_shot = pa.shot_fire;
    @(posedge Clk);
    #1;
    check("shot_one_cycle", 32'(pa.shot_fire), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vert"}, 32'(pa.vert_cmd), 32'd0);
    check({tag, "_move"}, 32'(pa.move_dir), 32'd0);
    check({tag, "_facing"}, 32'(pa.facing_right), 32'd1);
    check({tag, "_aim"}, 32'(pa.aim_up), 32'd0);
    check({tag, "_rolling"}, 32'(pa.rolling), 32'd0);
    check({tag, "_shot"}, 32'(pa.shot_fire), 32'd0);
  endtask

  task automatic keys_clear();
    k_up = 0; k_left = 0; k_down = 0; k_right = 0; k_z = 0; k_x = 0; k_gnd = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rise_cnt, roll_cnt, roll_shots;
    logic [1:0] v[4];
    logic [9:0] shot_mask;

    keys_clear();
    pa.frame_tick = 0; pa.up_on = 0; pa.left_on = 0; pa.down_on = 0; pa.right_on = 0;
    pa.z_jump_on = 0; pa.x_shoot_on = 0; pa.on_ground = 1;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_values("por");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Full-height jump then walk-off fall and landing.
    rise_cnt = 0;
    k_z = 1; tick();
    if (obs_vert == 2'b01) rise_cnt++;
    k_gnd = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (obs_vert == 2'b01) rise_cnt++;
    end
    check("rise_len", 32'(rise_cnt), 32'd16);
    check("fall_after_max", 32'(obs_vert), 32'd2);
    k_gnd = 1; tick();
    check("land", 32'(obs_vert), 32'd0);
    k_z = 0; tick();

    // Short hop released on the fourth tick.
    k_z = 1; tick(); v[0] = obs_vert;
    tick(); v[1] = obs_vert;
    tick(); v[2] = obs_vert;
    k_z = 0; tick(); v[3] = obs_vert;
    check("hop_t1", 32'(v[0]), 32'd1);
    check("hop_t3", 32'(v[2]), 32'd1);
    check("hop_t4", 32'(v[3]), 32'd2);
    tick();

    // Shot presses at ticks 1, 3, 9.
    shot_mask = '0;
    for (int t = 1; t <= 10; t++) begin
      k_x = (t == 1 || t == 3 || t == 9);
      tick();
      shot_mask[t-1] = obs_shot;
    end
    check("shot_pattern", 32'(shot_mask), 32'h101);
    k_x = 0;

    // Walking and conflicting direction keys.
    k_right = 1; tick();
    check("walk_right", 32'(obs_move), 32'd2);
    k_left = 1; tick();
    check("both_stop", 32'(obs_move), 32'd0);
    check("both_keep_facing_r", 32'(obs_facing), 32'd1);
    k_right = 0; tick();
    check("walk_left", 32'(obs_move), 32'd1);
    k_right = 1; tick();
    check("both_keep_facing_l", 32'(obs_facing), 32'd0);
    k_left = 0; k_right = 0; tick();

    // Jump beats roll on a simultaneous press.
    k_down = 1; k_z = 1; tick();
    check("jump_wins_vert", 32'(obs_vert), 32'd1);
    check("jump_wins_roll", 32'(obs_rolling), 32'd0);
    k_down = 0; k_z = 0; tick();
    tick();
    check("back_on_ground", 32'(obs_vert), 32'd0);

    // Roll facing left with right held and x tapped.
    k_right = 1; k_down = 1; tick();
    roll_cnt = obs_rolling ? 1 : 0;
    check("roll_dir", 32'(obs_move), 32'd1);
    roll_shots = 0;
    for (int i = 0; i < 12; i++) begin
      k_x = (i % 2 == 0);
      tick();
      if (obs_rolling) roll_cnt++;
      if (obs_shot) roll_shots++;
    end
    check("roll_len", 32'(roll_cnt), 32'd12);
    check("roll_no_shot", 32'(roll_shots), 32'd0);
    keys_clear();
    repeat (3) tick();

    // Asynchronous reset in the middle of a rise.
    k_up = 1; k_right = 1; k_z = 1; tick(); tick();
    check("pre_reset_rise", 32'(obs_vert), 32'd1);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    sb_q.delete();
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check("first_tick_jump", 32'(obs_vert), 32'd1);
    keys_clear();
    repeat (3) tick();

    // Random key traffic against the model.
    for (int i = 0; i < 300; i++) begin
      k_up = 1'($urandom_range(0, 1)); k_left = 1'($urandom_range(0, 1));
      k_right = 1'($urandom_range(0, 1)); k_down = 1'($urandom_range(0, 1));
      k_z = ($urandom_range(0, 3) != 0); k_x = 1'($urandom_range(0, 1));
      k_gnd = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
